param_alu_core: RTL and testbench
=================================

PARAM_ALU_CORE -- requirements
Module: param_alu_core

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-005 The block SHALL have port op  input  4  operation select, encodings from alu_pkg.
REQ-006 The block SHALL have ports a and b  input  WIDTH  operands, latched on an accepted start.
REQ-007 The block SHALL have port y  output  WIDTH  registered result, low half for MUL.
REQ-008 The block SHALL have port y_hi  output  WIDTH  registered high half of the MUL product; zero for all other ops.
REQ-009 The block SHALL have port flags  output  4  registered {N,Z,C,V}.
REQ-010 The block SHALL have port busy  output  1  high while a multi-cycle op is in progress.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse marking result update or error.
REQ-012 The block SHALL have port err  output  1  one-cycle pulse, coincident with done, for an illegal op.

Function
REQ-013 The FSM SHALL have states IDLE and MUL; start in IDLE with op MUL goes to MUL, otherwise stays in IDLE.
REQ-014 For a single-cycle op, y, y_hi, flags and done SHALL update at the first edge after the edge at which start is sampled (latency 1).
REQ-015 Op encodings SHALL be 0 ADD, 1 SUB, 2 NEG, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SAR, 8 MUL; 9..15 SHALL be illegal.
REQ-016 ADD/SUB/NEG SHALL compute modulo 2^WIDTH: C is carry-out for ADD and borrow (a<b unsigned) for SUB/NEG, and V is two's-complement signed overflow.
REQ-017 NEG of the most negative value (0x80 at WIDTH=8) SHALL return the same value with V=1.
REQ-018 AND/OR/XOR SHALL clear C and V; SHL shifts a left by 1 with C=a[WIDTH-1]; SAR shifts a right by 1 arithmetically with C=a[0]; V=0 for both shifts.
REQ-019 Z SHALL be set when y==0, and N SHALL equal y[WIDTH-1], for every legal op.
REQ-020 MUL SHALL be unsigned shift-add over exactly WIDTH cycles, with busy high from the accept edge until the edge that asserts done.
REQ-021 MUL done SHALL assert at edge k+WIDTH, where k is the accept edge.
REQ-022 MUL results SHALL be {y_hi,y}=a*b with C=V=(y_hi!=0).
REQ-023 start SHALL be ignored while busy; op, a and b changes during MUL SHALL NOT affect the result.
REQ-024 An illegal op SHALL pulse done and err together after 1 cycle and leave y, y_hi and flags unchanged.
REQ-025 Between operations, y, y_hi and flags SHALL hold their last values.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE and clear y, y_hi, flags, busy, done and err to 0, including mid-MUL.
REQ-027 After reset deassertion, the first start SHALL be accepted at the first clk edge.

Configuration
REQ-028 With macro ALU_MUL_EN defined, the MUL state and iterative multiplier SHALL be compiled in.
REQ-029 With ALU_MUL_EN undefined, op 8 SHALL be illegal per REQ-024, busy SHALL tie to 0, and y_hi SHALL tie to 0.

Structure
REQ-030 Package alu_pkg SHALL hold the op encoding constants, the flag bit indices (N=3,Z=2,C=1,V=0) and the state typedef.
REQ-031 The shift-add multiplier SHALL be one sub-module, alu_seq_mul, instantiated only under ALU_MUL_EN.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F b=0x01 -> y=0x80, flags N=1 Z=0 C=0 V=1, done one cycle later.
REQ-033 SUB a=0x00 b=0x01 -> y=0xFF, N=1 C=1 V=0; NEG a=0x80 -> y=0x80, V=1.
REQ-034 MUL a=0x0F b=0x11 -> busy for 8 cycles; done at k+8; y=0xFF, y_hi=0x00, C=V=0; a second start during busy is ignored.
REQ-035 MUL a=0xFF b=0xFF -> y=0x01, y_hi=0xFE, C=V=1.
REQ-036 Reset asserted at the 4th MUL cycle -> all outputs 0 immediately; a subsequent ADD 0x02+0x03 -> y=0x05.
REQ-037 op=0xF -> done=1 and err=1 for one cycle, with y and flags unchanged from the prior operation.

Source files
------------

// File: rtl/param_alu_core_pkg.sv
// alu_pkg: op encodings, flag bit indices and FSM state type for param_alu_core.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NEG = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SAR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;
    typedef logic [0:0] state_t;
    localparam state_t S_IDLE = 1'b0;
    localparam state_t S_MUL  = 1'b1;
endpackage

// File: rtl/param_alu_core_if.sv
// param_alu_core_if: request/result bundle between a requester and param_alu_core.
interface param_alu_core_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b, y, y_hi;
    logic [3:0]       flags;
    logic             busy, done, err;
    modport master (output start, op, a, b, input y, y_hi, flags, busy, done, err);
    modport slave  (input start, op, a, b, output y, y_hi, flags, busy, done, err);
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: unsigned shift-add multiplier, one partial product per cycle; p is the next product state.
module alu_seq_mul #(parameter int WIDTH = 8) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p,
    output logic               last
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     sum;
    // upper half accumulates the multiplicand, then the whole register shifts right
    assign sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mc & {WIDTH{acc[0]}}};
    assign p    = {sum, acc[WIDTH-1:1]};
    assign last = cnt == CW'(WIDTH - 1);
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            acc <= '0;
            mc  <= '0;
            cnt <= '0;
        end else if (load) begin
            acc <= {{WIDTH{1'b0}}, b};
            mc  <= a;
            cnt <= '0;
        end else if (en) begin
            acc <= p;
            cnt <= cnt + 1'b1;
        end
endmodule

// File: rtl/param_alu_core.sv
// param_alu_core: registered ALU with 1-cycle ops and an iterative MUL.
// MUL and the alu_seq_mul instance exist only when ALU_MUL_EN is defined; otherwise op 8 is illegal.
module param_alu_core import alu_pkg::*; #(parameter int WIDTH = 8) (
    input logic clk,
    input logic reset,
    param_alu_core_if.slave bus
);
    state_t             st;
    logic               go, acc, is_mul, mul_done, legal, c, v;
    logic [3:0]         opr;
    logic [WIDTH-1:0]   ra, rb, r;
    logic [2*WIDTH-1:0] p;
    assign acc      = bus.start && st == S_IDLE;
    assign bus.busy = st == S_MUL;
`ifdef ALU_MUL_EN
    logic last;
    assign is_mul   = bus.op == OP_MUL;
    assign mul_done = bus.busy && last;
    alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
        .clk(clk), .reset(reset), .load(acc && is_mul), .en(bus.busy),
        .a(bus.a), .b(bus.b), .p(p), .last(last)
    );
`else
    assign is_mul   = 1'b0;
    assign mul_done = 1'b0;
    assign p        = '0;
`endif
    always_comb begin
        r     = '0;
        c     = 1'b0;
        v     = 1'b0;
        legal = 1'b1;
        case (opr)
            OP_ADD: begin
                {c, r} = {1'b0, ra} + {1'b0, rb};
                v = ra[WIDTH-1] == rb[WIDTH-1] && r[WIDTH-1] != ra[WIDTH-1];
            end
            OP_SUB: begin
                r = ra - rb;
                c = ra < rb;
                v = ra[WIDTH-1] != rb[WIDTH-1] && r[WIDTH-1] != ra[WIDTH-1];
            end
            OP_NEG: begin
                r = '0 - ra;
                c = ra != '0;
                v = ra[WIDTH-1] && r[WIDTH-1];
            end
            OP_AND: r = ra & rb;
            OP_OR:  r = ra | rb;
            OP_XOR: r = ra ^ rb;
            OP_SHL: {c, r} = {ra, 1'b0};
            OP_SAR: {r, c} = {ra[WIDTH-1], ra};
            default: legal = 1'b0;
        endcase
    end
    // operands are latched at accept; results land one edge later (or at the last MUL step)
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            st        <= S_IDLE;
            go        <= 1'b0;
            opr       <= '0;
            ra        <= '0;
            rb        <= '0;
            bus.y     <= '0;
            bus.y_hi  <= '0;
            bus.flags <= '0;
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
        end else begin
            st       <= acc && is_mul ? S_MUL : mul_done ? S_IDLE : st;
            go       <= acc && !is_mul;
            bus.done <= go || mul_done;
            bus.err  <= go && !legal;
            if (acc) begin
                opr <= bus.op;
                ra  <= bus.a;
                rb  <= bus.b;
            end
            if (go && legal) begin
                bus.y     <= r;
                bus.y_hi  <= '0;
                bus.flags <= {r[WIDTH-1], r == '0, c, v};
            end else if (mul_done) begin
                bus.y     <= p[WIDTH-1:0];
                bus.y_hi  <= p[2*WIDTH-1:WIDTH];
                bus.flags <= {p[WIDTH-1], p[WIDTH-1:0] == '0, p[2*WIDTH-1:WIDTH] != '0, p[2*WIDTH-1:WIDTH] != '0};
            end
        end
endmodule

// File: tb/tb_param_alu_core.sv
// tb_param_alu_core: directed and random checks of param_alu_core (WIDTH=8) against an arithmetic reference model.
module tb_param_alu_core;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] exp_y = '0, exp_hi = '0;
    logic [3:0] exp_f = '0;
    param_alu_core_if #(.WIDTH(8)) bus ();
    param_alu_core #(.WIDTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic cmp8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic cmp1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask
    task automatic outs(input string tag, input logic edone, input logic eerr, input logic ebusy);
        cmp8({tag, ".y"}, bus.y, exp_y);
        cmp8({tag, ".y_hi"}, bus.y_hi, exp_hi);
        cmp8({tag, ".flags"}, {4'b0, bus.flags}, {4'b0, exp_f});
        cmp1({tag, ".done"}, bus.done, edone);
        cmp1({tag, ".err"}, bus.err, eerr);
        cmp1({tag, ".busy"}, bus.busy, ebusy);
    endtask
    // reference: integer arithmetic over the op definitions
    task automatic model(input int op, input int a, input int b, output logic [7:0] ny, output logic [7:0] nhi,
                         output logic [3:0] nf, output bit legal, output bit mul);
        int sa, sb, s, yy, hi;
        bit c, v;
        sa = a > 127 ? a - 256 : a;
        sb = b > 127 ? b - 256 : b;
        yy = 0; hi = 0; c = 0; v = 0; legal = 1; mul = 0;
        case (op)
            0: begin s = a + b; yy = s % 256; c = s > 255; v = sa + sb > 127 || sa + sb < -128; end
            1: begin yy = (a - b + 256) % 256; c = a < b; v = sa - sb > 127 || sa - sb < -128; end
            2: begin yy = (256 - a) % 256; c = a > 0; v = -sa > 127; end
            3: yy = a & b;
            4: yy = a | b;
            5: yy = a ^ b;
            6: begin yy = (a * 2) % 256; c = a >= 128; end
            7: begin yy = ((sa >>> 1) + 256) % 256; c = (a % 2) == 1; end
            8: if (MUL_EN) begin s = a * b; yy = s % 256; hi = s / 256; c = hi != 0; v = c; mul = 1; end
               else legal = 0;
            default: legal = 0;
        endcase
        ny = yy[7:0];
        nhi = hi[7:0];
        nf = {yy >= 128, yy == 0, c, v};
    endtask
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] ny, nhi;
        logic [3:0] nf;
        bit legal, mul;
        model(int'(op), int'(a), int'(b), ny, nhi, nf, legal, mul);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
        outs({tag, ".acc"}, 1'b0, 1'b0, mul);
        if (mul)
            for (int i = 1; i < 8; i++) begin
                @(posedge clk); #1;
                cmp1({tag, ".busy"}, bus.busy, 1'b1);
                cmp1({tag, ".done_early"}, bus.done, 1'b0);
                bus.start = 1'b1; bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
            end
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (legal) begin exp_y = ny; exp_hi = nhi; exp_f = nf; end
        outs({tag, ".res"}, 1'b1, !legal, 1'b0);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    initial begin
        logic [3:0] op;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        outs("reset", 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        run_op("add7f", 4'd0, 8'h7F, 8'h01);
        cmp8("add7f.const_y", bus.y, 8'h80);
        cmp8("add7f.const_f", {4'b0, bus.flags}, 8'b1001);
        run_op("sub0", 4'd1, 8'h00, 8'h01);
        cmp8("sub0.const_f", {4'b0, bus.flags}, 8'b1010);
        run_op("neg80", 4'd2, 8'h80, 8'h00);
        cmp8("neg80.const_y", bus.y, 8'h80);
        cmp1("neg80.const_v", bus.flags[0], 1'b1);
        run_op("mul0f", 4'd8, 8'h0F, 8'h11);
        run_op("mulff", 4'd8, 8'hFF, 8'hFF);
        run_op("illegal", 4'hF, 8'h12, 8'h34);
        bus.start = 1'b1; bus.op = 4'd8; bus.a = 8'hFF; bus.b = 8'h02;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        exp_y = '0; exp_hi = '0; exp_f = '0;
        outs("rst_mid", 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_op("add23", 4'd0, 8'h02, 8'h03);
        cmp8("add23.const_y", bus.y, 8'h05);
        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            run_op("rand", op, 8'($urandom), 8'($urandom));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
